// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for sync_fifo_v2.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    // Storage index width; a depth of 1 still needs one address bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic bit is_pow2(input int v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

    // Thresholds must sit inside the occupancy range and leave a gap
    // between almost_empty and almost_full.
    function automatic bit levels_ok(input int depth, input int af, input int ae);
        return (af >= 1) && (af <= depth) && (ae >= 0) && (ae < depth) && (ae < af);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem_2p #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write port: store the word on an accepted write.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_v2.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and sticky overflow/underflow flags cleared by err_clr.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata
// is a registered copy of the head, updated on each accepted read.
module sync_fifo_v2
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int PTR_W   = ptr_width(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             underflow
);

    generate
        if (!is_pow2(DEPTH)) begin : g_bad_depth
            $error("sync_fifo_v2: DEPTH must be a power of two >= 2");
        end
        if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
            $error("sync_fifo_v2: AF_LEVEL/AE_LEVEL out of range or AE_LEVEL >= AF_LEVEL");
        end
    endgenerate

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

    // MSB of each pointer is the wrap bit; the low bits address storage.
    logic [PTR_W:0]     r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]   r_count, w_cnt_nxt;
    logic               r_ovf, r_udf;
    logic               w_full, w_empty, w_wr_ok, w_rd_ok;
    logic [WIDTH-1:0]   w_mem_rdata;

    // Flags come only from registered occupancy.
    assign w_full  = (r_count == DEPTH_C);
    assign w_empty = (r_count == '0);

    // A read frees a slot in the same cycle, so a full FIFO may still accept
    // a simultaneous write.
    assign w_rd_ok = rd_en && !w_empty;
    assign w_wr_ok = wr_en && (!w_full || w_rd_ok);

    fifo_mem_2p #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_ok),
        .i_waddr (r_wr_ptr[PTR_W-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rd_ptr[PTR_W-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // Next occupancy: +1 on write only, -1 on read only, else unchanged.
    always_comb begin
        w_cnt_nxt = r_count;
        case ({w_wr_ok, w_rd_ok})
            2'b10:   w_cnt_nxt = r_count + 1'b1;
            2'b01:   w_cnt_nxt = r_count - 1'b1;
            default: w_cnt_nxt = r_count;
        endcase
    end

    // Pointers, count and sticky error flags; a new error wins over err_clr.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_cnt_nxt;
            r_ovf   <= (r_ovf && !err_clr) || (wr_en && !w_wr_ok);
            r_udf   <= (r_udf && !err_clr) || (rd_en && !w_rd_ok);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented directly; rd_en pops it.
    assign rdata = w_mem_rdata;
`else
    logic [WIDTH-1:0] r_rdata;

    // Registered read: capture the head on an accepted read, hold otherwise.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n)       r_rdata <= '0;
        else if (w_rd_ok) r_rdata <= w_mem_rdata;
    end

    assign rdata = r_rdata;
`endif

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule
